reorder_buffer: RTL

- Parametrised circular reorder buffer between rename/dispatch and commit in the out-of-order core.
- Allocates up to DISP_W entries per cycle in program order and marks entries complete from WB_PORTS writeback ports.
- Retires up to RET_W completed head entries per cycle, in order.
- On a retiring branch mispredict or exception, stops retirement at that entry and performs a one-cycle full flush.

---
 rtl/core_pkg.sv | 31 +++
 rtl/reorder_buffer_if.sv | 41 ++++
 rtl/reorder_buffer_retire_select.sv | 42 ++++
 rtl/reorder_buffer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types for the reorder buffer: entry payload, index type, flush cause
// and the default sizing used by ROB parameters.
package core_pkg;

  localparam int unsigned NUM_ROB_ENTS = 64;
  localparam int unsigned RETIRE_WIDTH = 4;
  localparam int unsigned DISP_WIDTH   = 2;
  localparam int unsigned NUM_FUS      = 4;
  localparam int unsigned ROB_IDX_W    = $clog2(NUM_ROB_ENTS);

  typedef logic [ROB_IDX_W-1:0] rob_idx_t;

  typedef struct packed {
    logic [4:0]  dst_areg;
    logic [6:0]  dst_preg;
    logic        exception;
    logic        br_mispred;
    logic [31:0] pc;
  } ROB_Entry;

  typedef enum logic {
    FLUSH_MISPRED   = 1'b0,
    FLUSH_EXCEPTION = 1'b1
  } flush_cause_t;

  typedef enum logic {
    StNormal = 1'b0,
    StFlush  = 1'b1
  } rob_state_e;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, writeback, retire and flush signals of the reorder buffer.
// slave is the ROB side, master the surrounding pipeline.
interface reorder_buffer_if
  import core_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = NUM_ROB_ENTS,
  parameter int unsigned DISP_W      = DISP_WIDTH,
  parameter int unsigned RET_W       = RETIRE_WIDTH,
  parameter int unsigned WB_PORTS    = NUM_FUS
);
  localparam int unsigned IdxW = $clog2(NUM_ENTRIES);

  logic [DISP_W-1:0]                disp_valid;
  ROB_Entry [DISP_W-1:0]            disp_entry;
  logic                             disp_ready;
  logic [DISP_W-1:0][IdxW-1:0]      disp_rob_idx;
  logic [WB_PORTS-1:0]              wb_valid;
  logic [WB_PORTS-1:0][IdxW-1:0]    wb_rob_idx;
  logic [WB_PORTS-1:0]              wb_exception;
  logic [WB_PORTS-1:0]              wb_br_mispred;
  logic [RET_W-1:0]                 ret_valid;
  ROB_Entry [RET_W-1:0]             ret_entry;
  logic                             flush;
  logic [31:0]                      flush_pc;
  flush_cause_t                     flush_cause;
  logic [IdxW:0]                    rob_count;
  logic                             rob_empty;

  modport master (
    output disp_valid, disp_entry, wb_valid, wb_rob_idx, wb_exception, wb_br_mispred,
    input  disp_ready, disp_rob_idx, ret_valid, ret_entry, flush, flush_pc, flush_cause,
           rob_count, rob_empty
  );

  modport slave (
    input  disp_valid, disp_entry, wb_valid, wb_rob_idx, wb_exception, wb_br_mispred,
    output disp_ready, disp_rob_idx, ret_valid, ret_entry, flush, flush_pc, flush_cause,
           rob_count, rob_empty
  );

endinterface

// File: rtl/reorder_buffer_retire_select.sv
// In-order scan of the head window: picks retiring lanes and detects the first
// flagged entry, which retires alone at the end of the group and triggers a flush.
module rob_retire_select
  import core_pkg::*;
#(
  parameter int unsigned RET_W = RETIRE_WIDTH
) (
  input  logic                  i_en,
  input  logic [RET_W-1:0]      i_valid,
  input  logic [RET_W-1:0]      i_done,
  input  logic [RET_W-1:0]      i_exc,
  input  logic [RET_W-1:0]      i_mis,
  input  logic [RET_W-1:0][31:0] i_pc,
  output logic [RET_W-1:0]      o_ret_valid,
  output logic                  o_flush_retire,
  output logic [31:0]           o_flush_pc,
  output flush_cause_t          o_flush_cause
);

  always_comb begin
    logic w_stop;
    w_stop         = ~i_en;
    o_ret_valid    = '0;
    o_flush_retire = 1'b0;
    o_flush_pc     = '0;
    o_flush_cause  = FLUSH_MISPRED;
    for (int k = 0; k < int'(RET_W); k++) begin
      if (!w_stop && i_valid[k] && i_done[k]) begin
        o_ret_valid[k] = 1'b1;
        if (i_exc[k] || i_mis[k]) begin
          o_flush_retire = 1'b1;
          o_flush_pc     = i_pc[k];
          o_flush_cause  = i_exc[k] ? FLUSH_EXCEPTION : FLUSH_MISPRED;
          w_stop         = 1'b1;
        end
      end else begin
        w_stop = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order completion, in-order
// retire of up to RET_W entries, and a one-cycle full flush on a flagged retire.
module reorder_buffer
  import core_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = NUM_ROB_ENTS,
  parameter int unsigned DISP_W      = DISP_WIDTH,
  parameter int unsigned RET_W       = RETIRE_WIDTH,
  parameter int unsigned WB_PORTS    = NUM_FUS
) (
  input  logic             clk,
  input  logic             rst,
  reorder_buffer_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(NUM_ENTRIES);
  localparam int unsigned PtrW = IdxW + 1;

  rob_state_e           r_state, w_state_next;
  logic [PtrW-1:0]      r_head, r_tail;
  logic [NUM_ENTRIES-1:0] r_valid, r_done, r_exc, r_mis;
  ROB_Entry             r_entry [NUM_ENTRIES];
  logic [31:0]          r_flush_pc;
  flush_cause_t         r_flush_cause;

  logic [PtrW-1:0]      w_count, w_free, w_head_next, w_disp_cnt, w_ret_cnt;
  logic [IdxW-1:0]      w_lane_idx [RET_W];
  logic [IdxW-1:0]      w_disp_idx [DISP_W];
  logic [RET_W-1:0]     w_lane_valid, w_lane_done, w_lane_exc, w_lane_mis, w_ret_valid;
  logic [RET_W-1:0][31:0] w_lane_pc;
  ROB_Entry [RET_W-1:0] w_ret_entry;
  logic                 w_normal, w_disp_ready, w_disp_fire, w_flush_retire;
  logic [31:0]          w_flush_pc;
  flush_cause_t         w_flush_cause;

  assign w_normal = (r_state == StNormal);
  assign w_count  = r_tail - r_head;
  assign w_free   = PtrW'(NUM_ENTRIES) - w_count;

  // Gather the head window; flags live in separate vectors so writebacks can OR into them.
  always_comb begin
    for (int k = 0; k < int'(RET_W); k++) begin
      w_lane_idx[k]             = IdxW'(r_head + PtrW'(k));
      w_lane_valid[k]           = r_valid[w_lane_idx[k]];
      w_lane_done[k]            = r_done[w_lane_idx[k]];
      w_lane_exc[k]             = r_exc[w_lane_idx[k]];
      w_lane_mis[k]             = r_mis[w_lane_idx[k]];
      w_ret_entry[k]            = r_entry[w_lane_idx[k]];
      w_ret_entry[k].exception  = w_lane_exc[k];
      w_ret_entry[k].br_mispred = w_lane_mis[k];
      w_lane_pc[k]              = w_ret_entry[k].pc;
    end
  end

  rob_retire_select #(
    .RET_W (RET_W)
  ) u_retire_select (
    .i_en           (w_normal && !rst),
    .i_valid        (w_lane_valid),
    .i_done         (w_lane_done),
    .i_exc          (w_lane_exc),
    .i_mis          (w_lane_mis),
    .i_pc           (w_lane_pc),
    .o_ret_valid    (w_ret_valid),
    .o_flush_retire (w_flush_retire),
    .o_flush_pc     (w_flush_pc),
    .o_flush_cause  (w_flush_cause)
  );

  always_comb begin
    w_disp_cnt = '0;
    for (int l = 0; l < int'(DISP_W); l++) begin
      w_disp_idx[l] = IdxW'(r_tail + PtrW'(l));
      w_disp_cnt    = w_disp_cnt + PtrW'(bus.disp_valid[l]);
    end
    w_ret_cnt = '0;
    for (int k = 0; k < int'(RET_W); k++) begin
      w_ret_cnt = w_ret_cnt + PtrW'(w_ret_valid[k]);
    end
  end

  assign w_head_next  = r_head + w_ret_cnt;
  assign w_disp_ready = !rst && w_normal && (w_free >= PtrW'(DISP_W)) && !w_flush_retire;
  assign w_disp_fire  = w_disp_ready && bus.disp_valid[0];

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StNormal: if (w_flush_retire) w_state_next = StFlush;
      StFlush:  w_state_next = StNormal;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StNormal;
      r_head        <= '0;
      r_tail        <= '0;
      r_valid       <= '0;
      r_done        <= '0;
      r_exc         <= '0;
      r_mis         <= '0;
      r_flush_pc    <= '0;
      r_flush_cause <= FLUSH_MISPRED;
    end else begin
      r_state <= w_state_next;
      r_head  <= w_head_next;
      if (w_normal) begin
        for (int p = 0; p < int'(WB_PORTS); p++) begin
          if (bus.wb_valid[p] && r_valid[bus.wb_rob_idx[p]]) begin
            r_done[bus.wb_rob_idx[p]] <= 1'b1;
            r_exc[bus.wb_rob_idx[p]]  <= r_exc[bus.wb_rob_idx[p]] | bus.wb_exception[p];
            r_mis[bus.wb_rob_idx[p]]  <= r_mis[bus.wb_rob_idx[p]] | bus.wb_br_mispred[p];
          end
        end
      end
      for (int k = 0; k < int'(RET_W); k++) begin
        if (w_ret_valid[k]) begin
          r_valid[w_lane_idx[k]] <= 1'b0;
          r_done[w_lane_idx[k]]  <= 1'b0;
          r_exc[w_lane_idx[k]]   <= 1'b0;
          r_mis[w_lane_idx[k]]   <= 1'b0;
        end
      end
      if (w_disp_fire) begin
        r_tail <= r_tail + w_disp_cnt;
        for (int l = 0; l < int'(DISP_W); l++) begin
          if (bus.disp_valid[l]) begin
            r_valid[w_disp_idx[l]] <= 1'b1;
            r_done[w_disp_idx[l]]  <= 1'b0;
            r_exc[w_disp_idx[l]]   <= bus.disp_entry[l].exception;
            r_mis[w_disp_idx[l]]   <= bus.disp_entry[l].br_mispred;
          end
        end
      end
      // Flush wins: everything younger than the flagged entry is discarded.
      if (w_flush_retire) begin
        r_valid       <= '0;
        r_done        <= '0;
        r_tail        <= w_head_next;
        r_flush_pc    <= w_flush_pc;
        r_flush_cause <= w_flush_cause;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_disp_fire) begin
      for (int l = 0; l < int'(DISP_W); l++) begin
        if (bus.disp_valid[l]) r_entry[w_disp_idx[l]] <= bus.disp_entry[l];
      end
    end
  end

  always_comb begin
    bus.disp_ready = w_disp_ready;
    for (int l = 0; l < int'(DISP_W); l++) bus.disp_rob_idx[l] = w_disp_idx[l];
    bus.ret_valid   = w_ret_valid;
    bus.ret_entry   = w_ret_entry;
    bus.flush       = !rst && (r_state == StFlush);
    bus.flush_pc    = rst ? 32'h0 : r_flush_pc;
    bus.flush_cause = rst ? FLUSH_MISPRED : r_flush_cause;
    bus.rob_count   = rst ? '0 : w_count;
    bus.rob_empty   = rst || (w_count == '0);
  end

endmodule
